fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Round-robin, packet-locked arbiter sharing one async FIFO push port (W_nEN / W_DATA / W_FULL) among REQ_COUNT write-side requesters.
- Runs entirely in the w_clk domain, in front of the FIFO write interface.
- Tags every pushed word with the source requester ID so the read-clock side can demultiplex.

Parameters:
REQ_COUNT, 4, number of requesters (2..16)
DATA_WIDTH, 32, payload width per requester
ID_WIDTH, 2, width of W_ID; must satisfy 2**ID_WIDTH >= REQ_COUNT
TIMEOUT_CYCLES, 64, stall limit used only by the optional feature (1..65535)

Ports:
w_clk  input  1  write-domain clock
nRST  input  1  asynchronous active-low reset
REQ_VALID  input  REQ_COUNT  per-requester word valid
REQ_LAST  input  REQ_COUNT  per-requester last word of packet
REQ_DATA  input  REQ_COUNT*DATA_WIDTH  payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
REQ_READY  output  REQ_COUNT  word accepted when REQ_VALID[i] & REQ_READY[i]
W_nEN  output  1  FIFO push enable, active-low
W_DATA  output  DATA_WIDTH  FIFO push data
W_ID  output  ID_WIDTH  source ID of the pushed word
W_FULL  input  1  FIFO full flag (write domain)
GRANT_ID  output  ID_WIDTH  currently / last granted requester
BUSY  output  1  high in XFER state
ERR_TIMEOUT  output  1  one-cycle pulse on stall abort; tied 0 without the feature

Behaviour:
- Reset (nRST low, async): state=IDLE; rr_ptr=0; GRANT_ID=0; BUSY=0; REQ_READY=0; W_nEN=1; ERR_TIMEOUT=0.
- States: IDLE, XFER.
- IDLE: if any REQ_VALID is high, pick the first set bit searching upward from rr_ptr, wrapping modulo REQ_COUNT.
  - Register the winner into GRANT_ID, enter XFER next cycle.
  - No push in IDLE, so there is a 1-cycle arbitration bubble per packet.
- XFER, combinational outputs:
  - REQ_READY[g] = ~W_FULL, where g = GRANT_ID; all other REQ_READY = 0.
  - W_nEN = ~(REQ_VALID[g] & ~W_FULL).
  - W_DATA = REQ_DATA slice g; W_ID = g.
- Beat: push occurs on any cycle with W_nEN=0. A push with REQ_LAST[g]=1 sets rr_ptr=(g+1) mod REQ_COUNT and returns to IDLE.
- Packet lock: grant held until the last beat; new REQ_VALIDs from others ignored meanwhile.
- W_FULL high: no push, no ready; data must remain stable (requester obligation); state held.
- REQ_VALID[g] low mid-packet: idle cycles, grant held.
- Single-word packet (VALID & LAST on the first beat): XFER lasts 1 cycle if not full.
- rr_ptr wrap: g=REQ_COUNT-1 yields rr_ptr=0.
- Reset mid-packet: immediate return to reset values; partial packet already in the FIFO is not retracted.
- Outputs W_DATA / W_ID undefined-but-driven when W_nEN=1 (drive slice g).

Optional Feature:
- Macro FIFO_WR_ARB_TIMEOUT_EN.
- Defined:
  - 16-bit stall counter in XFER increments on every cycle with REQ_VALID[g]=0 while W_FULL=0.
  - Counter clears on each push and on entering XFER.
  - Reaching TIMEOUT_CYCLES: ERR_TIMEOUT pulses 1 cycle, rr_ptr=(g+1) mod REQ_COUNT, state -> IDLE.
  - Stalls due to W_FULL never count.
- Undefined: no counter; ERR_TIMEOUT constant 0; grant held indefinitely.

Test Plan:
- Req1 sends 3-word packet 0x10,0x11,0x12 (LAST on 0x12), FIFO empty -> GRANT_ID=1 one cycle after VALID; three consecutive pushes with W_ID=1; BUSY drops next cycle; rr_ptr=2.
- Req0 and Req3 both valid from reset, single-word packets repeated -> grants alternate 0,3,0,3; each packet takes 2 cycles.
- W_FULL forced high during the 2nd word of a 4-word Req2 packet for 5 cycles -> W_nEN=1 and REQ_READY[2]=0 for those 5 cycles; words arrive in order, none lost or duplicated.
- Req1 mid-packet while Req0 asserts VALID -> Req0 waits until Req1 LAST is pushed, then is granted after the 1-cycle IDLE bubble.
- nRST pulsed low during the 2nd beat of a Req3 packet -> all outputs return to reset values asynchronously; the next grant after release goes to the lowest valid requester from rr_ptr=0.
- With FIFO_WR_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8: Req2 drops VALID after word 1 -> ERR_TIMEOUT pulses 8 cycles later; a waiting Req3 is granted next.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Requester handshake and FIFO push signals shared by the write-side arbiter and its environment.
interface fifo_wr_arbiter_if #(
   parameter int REQ_COUNT  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 2
);
   logic [REQ_COUNT-1:0]            REQ_VALID;
   logic [REQ_COUNT-1:0]            REQ_LAST;
   logic [REQ_COUNT*DATA_WIDTH-1:0] REQ_DATA;
   logic [REQ_COUNT-1:0]            REQ_READY;
   logic                            W_nEN;
   logic [DATA_WIDTH-1:0]           W_DATA;
   logic [ID_WIDTH-1:0]             W_ID;
   logic                            W_FULL;
   logic [ID_WIDTH-1:0]             GRANT_ID;
   logic                            BUSY;
   logic                            ERR_TIMEOUT;

   modport master (
      input  REQ_VALID, REQ_LAST, REQ_DATA, W_FULL,
      output REQ_READY, W_nEN, W_DATA, W_ID, GRANT_ID, BUSY, ERR_TIMEOUT
   );

   modport slave (
      output REQ_VALID, REQ_LAST, REQ_DATA, W_FULL,
      input  REQ_READY, W_nEN, W_DATA, W_ID, GRANT_ID, BUSY, ERR_TIMEOUT
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin share of one FIFO push port; 1-cycle IDLE bubble per packet, W_FULL drops ready and push.
// FIFO_WR_ARB_TIMEOUT_EN adds a stall timeout that aborts a grant whose requester stays quiet for TIMEOUT_CYCLES.
module fifo_wr_arbiter #(
   parameter int REQ_COUNT      = 4,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              w_clk,
   input  logic              nRST,
   fifo_wr_arbiter_if.master bus
);
   localparam int NSLOT = 1 << ID_WIDTH;

   typedef enum logic {IDLE, XFER} state_t;

   state_t                state;
   logic [ID_WIDTH-1:0]   rr_ptr;
   logic [ID_WIDTH-1:0]   grant_id;
   logic [ID_WIDTH-1:0]   winner;
   logic [ID_WIDTH-1:0]   next_ptr;
   logic                  busy;
   logic                  any_vld;
   logic                  push;
   logic                  grant_last;
   logic [NSLOT-1:0]      vld_ext;
   logic [NSLOT-1:0]      last_ext;
   logic [NSLOT-1:0]      ready_ext;
   logic [DATA_WIDTH-1:0] data_arr [NSLOT];
   int                    slot;

   if (REQ_COUNT < 2 || REQ_COUNT > 16 || REQ_COUNT > NSLOT) begin : g_bad_count
      $error("fifo_wr_arbiter: REQ_COUNT must be 2..16 and fit in ID_WIDTH");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("fifo_wr_arbiter: TIMEOUT_CYCLES must be 1..65535");
   end

   // Pad per-requester vectors to the full ID space so grant_id indexes them directly.
   assign vld_ext  = NSLOT'(bus.REQ_VALID);
   assign last_ext = NSLOT'(bus.REQ_LAST);

   for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < REQ_COUNT) begin : g_used
         assign data_arr[gi] = bus.REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
      end else begin : g_unused
         assign data_arr[gi] = '0;
      end
   end

   // Walk downward so the smallest offset from rr_ptr is the last (winning) assignment.
   always_comb begin
      winner  = rr_ptr;
      any_vld = 1'b0;
      slot    = 0;
      for (int k = REQ_COUNT - 1; k >= 0; k--) begin
         slot = int'(rr_ptr) + k;
         if (slot >= REQ_COUNT) slot = slot - REQ_COUNT;
         if (vld_ext[ID_WIDTH'(slot)]) begin
            winner  = ID_WIDTH'(slot);
            any_vld = 1'b1;
         end
      end
   end

   assign grant_last = last_ext[grant_id];
   assign push       = (state == XFER) && vld_ext[grant_id] && !bus.W_FULL;
   assign next_ptr   = (int'(grant_id) == REQ_COUNT - 1) ? '0 : grant_id + 1'b1;

   always_comb begin
      ready_ext = '0;
      if (state == XFER) ready_ext[grant_id] = ~bus.W_FULL;
   end

   assign bus.REQ_READY = ready_ext[REQ_COUNT-1:0];
   assign bus.W_nEN     = ~push;
   assign bus.W_DATA    = data_arr[grant_id];
   assign bus.W_ID      = grant_id;
   assign bus.GRANT_ID  = grant_id;
   assign bus.BUSY      = busy;

`ifdef FIFO_WR_ARB_TIMEOUT_EN
   logic [15:0] stall_cnt;
   logic        err_timeout;
   logic        stall;

   // Only requester silence counts; FIFO backpressure never ages the grant.
   assign stall           = (state == XFER) && !vld_ext[grant_id] && !bus.W_FULL;
   assign bus.ERR_TIMEOUT = err_timeout;
`else
   assign bus.ERR_TIMEOUT = 1'b0;
`endif

   always_ff @(posedge w_clk or negedge nRST) begin
      if (!nRST) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
         busy     <= 1'b0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
         stall_cnt   <= '0;
         err_timeout <= 1'b0;
`endif
      end else begin
`ifdef FIFO_WR_ARB_TIMEOUT_EN
         err_timeout <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (any_vld) begin
                  grant_id <= winner;
                  busy     <= 1'b1;
                  state    <= XFER;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                  stall_cnt <= '0;
`endif
               end
            end
            XFER: begin
               if (push && grant_last) begin
                  rr_ptr <= next_ptr;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
               if (push) begin
                  stall_cnt <= '0;
               end else if (stall) begin
                  if (stall_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                     err_timeout <= 1'b1;
                     rr_ptr      <= next_ptr;
                     busy        <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     stall_cnt <= stall_cnt + 16'd1;
                  end
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester word queues drive the DUT, per-ID scoreboards check pushed words.
module tb_fifo_wr_arbiter;
   localparam int RC = 4;
   localparam int DW = 32;
   localparam int IW = 2;
   localparam int TO = 8;

   logic w_clk = 1'b0;
   logic nRST;

   always #5 w_clk = ~w_clk;

   fifo_wr_arbiter_if #(.REQ_COUNT(RC), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   fifo_wr_arbiter #(
      .REQ_COUNT(RC), .DATA_WIDTH(DW), .ID_WIDTH(IW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .w_clk(w_clk),
      .nRST (nRST),
      .bus  (bus)
   );

   logic [DW-1:0] dq [RC][$];
   bit            lq [RC][$];
   logic [DW-1:0] sb [RC][$];
   int            id_log[$];
   int            cyc_log[$];
   logic [RC-1:0] fire = '0;
   logic [RC-1:0] hold = '0;
   int            tests = 0;
   int            fails = 0;
   int            cyc = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int id, input logic [DW-1:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         dq[id].push_back(base + DW'(k));
         lq[id].push_back(k == n - 1);
         sb[id].push_back(base + DW'(k));
      end
   endtask

   function automatic bit all_empty();
      for (int i = 0; i < RC; i++) if (dq[i].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic drive();
      logic [RC-1:0]    v;
      logic [RC-1:0]    l;
      logic [RC*DW-1:0] d;
      v = '0; l = '0; d = '0;
      for (int i = 0; i < RC; i++) begin
         if (fire[i] && dq[i].size() > 0) begin
            void'(dq[i].pop_front());
            void'(lq[i].pop_front());
         end
         fire[i] = 1'b0;
         if (dq[i].size() > 0 && !hold[i]) begin
            v[i]           = 1'b1;
            l[i]           = lq[i][0];
            d[i*DW +: DW]  = dq[i][0];
         end
      end
      bus.REQ_VALID = v;
      bus.REQ_LAST  = l;
      bus.REQ_DATA  = d;
   endtask

   task automatic wait_push(input int id, input string tag);
      bit seen;
      int n;
      seen = 1'b0; n = 0;
      while (!seen && n < 50) begin
         @(negedge w_clk);
         n++;
         if (bus.W_nEN === 1'b0 && int'(bus.W_ID) == id) seen = 1'b1;
      end
      chk(tag, 64'(seen), 64'd1);
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      int n;
      done = 1'b0; n = 0;
      while (!done && n < 100) begin
         @(negedge w_clk);
         n++;
         if (all_empty() && bus.BUSY === 1'b0) done = 1'b1;
      end
      chk(tag, 64'(done), 64'd1);
   endtask

   task automatic chk_log(input string tag, input int exp[$]);
      chk({tag, "_count"}, 64'(id_log.size()), 64'(exp.size()));
      for (int k = 0; k < exp.size() && k < id_log.size(); k++)
         chk($sformatf("%s_id%0d", tag, k), 64'(id_log[k]), 64'(exp[k]));
   endtask

   task automatic clear_log();
      id_log.delete();
      cyc_log.delete();
   endtask

   initial forever begin
      @(posedge w_clk);
      cyc++;
   end

   // Requester model: retire a word the cycle after its handshake was observed.
   initial forever begin
      @(posedge w_clk);
      #1;
      drive();
   end

   initial forever begin
      int id;
      @(negedge w_clk);
      fire = bus.REQ_VALID & bus.REQ_READY;
      if (bus.W_nEN === 1'b0) begin
         id = int'(bus.W_ID);
         id_log.push_back(id);
         cyc_log.push_back(cyc);
         chk("push_ready", 64'(fire[id]), 64'd1);
         chk("push_expected", 64'(sb[id].size() > 0), 64'd1);
         if (sb[id].size() > 0) chk($sformatf("push_data_req%0d", id), 64'(bus.W_DATA), 64'(sb[id].pop_front()));
      end
   end

   initial begin
      bus.REQ_VALID = '0;
      bus.REQ_LAST  = '0;
      bus.REQ_DATA  = '0;
      bus.W_FULL    = 1'b0;
      nRST          = 1'b0;

      repeat (3) @(posedge w_clk);
      #2;
      chk("rst_busy",  64'(bus.BUSY),        64'd0);
      chk("rst_grant", 64'(bus.GRANT_ID),    64'd0);
      chk("rst_ready", 64'(bus.REQ_READY),   64'd0);
      chk("rst_wnen",  64'(bus.W_nEN),       64'd1);
      chk("rst_err",   64'(bus.ERR_TIMEOUT), 64'd0);
      @(negedge w_clk);
      nRST = 1'b1;
      repeat (2) @(negedge w_clk);

      // Req1 three-word packet with an empty FIFO.
      clear_log();
      send(1, 32'h10, 3);
      @(negedge w_clk);
      chk("t1_bubble_busy", 64'(bus.BUSY),  64'd0);
      chk("t1_bubble_wnen", 64'(bus.W_nEN), 64'd1);
      @(negedge w_clk);
      chk("t1_grant", 64'(bus.GRANT_ID), 64'd1);
      chk("t1_busy",  64'(bus.BUSY),     64'd1);
      chk("t1_wnen",  64'(bus.W_nEN),    64'd0);
      chk("t1_wid",   64'(bus.W_ID),     64'd1);
      wait_idle("t1_done");
      chk_log("t1", '{1, 1, 1});
      if (cyc_log.size() == 3) chk("t1_back_to_back", 64'(cyc_log[2] - cyc_log[0]), 64'd2);

      // Req0 and Req3 single-word packets; rr_ptr=2 after Req1 so Req3 goes first.
      clear_log();
      send(0, 32'h20, 1);
      send(0, 32'h21, 1);
      send(3, 32'h30, 1);
      send(3, 32'h31, 1);
      wait_idle("t2_done");
      chk_log("t2", '{3, 0, 3, 0});
      for (int k = 1; k < cyc_log.size(); k++)
         chk($sformatf("t2_spacing%0d", k), 64'(cyc_log[k] - cyc_log[k-1]), 64'd2);

      // Req2 four-word packet with FIFO full for five cycles on word 2.
      clear_log();
      send(2, 32'h40, 4);
      wait_push(2, "t3_first");
      @(posedge w_clk);
      #2 bus.W_FULL = 1'b1;
      repeat (5) begin
         @(negedge w_clk);
         chk("t3_full_wnen",  64'(bus.W_nEN),        64'd1);
         chk("t3_full_ready", 64'(bus.REQ_READY[2]), 64'd0);
         chk("t3_full_data",  64'(bus.W_DATA),       64'h41);
      end
      @(posedge w_clk);
      #2 bus.W_FULL = 1'b0;
      wait_idle("t3_done");
      chk_log("t3", '{2, 2, 2, 2});
      if (cyc_log.size() == 4) chk("t3_stall_len", 64'(cyc_log[1] - cyc_log[0]), 64'd6);

      // Req0 arrives mid-packet of Req1 and must wait for LAST plus the bubble.
      clear_log();
      send(1, 32'h50, 3);
      wait_push(1, "t4_first");
      send(0, 32'h58, 1);
      wait_idle("t4_done");
      chk_log("t4", '{1, 1, 1, 0});
      if (cyc_log.size() == 4) chk("t4_bubble", 64'(cyc_log[3] - cyc_log[2]), 64'd2);

      // Reset during the second beat of a Req3 packet.
      send(3, 32'h60, 3);
      wait_push(3, "t5_first");
      send(0, 32'h70, 1);
      send(2, 32'h78, 1);
      @(posedge w_clk);
      #2 nRST = 1'b0;
      #1;
      chk("t5_rst_busy",  64'(bus.BUSY),        64'd0);
      chk("t5_rst_grant", 64'(bus.GRANT_ID),    64'd0);
      chk("t5_rst_ready", 64'(bus.REQ_READY),   64'd0);
      chk("t5_rst_wnen",  64'(bus.W_nEN),       64'd1);
      chk("t5_rst_err",   64'(bus.ERR_TIMEOUT), 64'd0);
      dq[3].delete();
      lq[3].delete();
      sb[3].delete();
      clear_log();
      @(negedge w_clk);
      #1 nRST = 1'b1;
      wait_idle("t5_done");
      chk_log("t5", '{0, 2});

      // Req2 goes quiet after word 1 while Req3 waits.
      clear_log();
      send(2, 32'h80, 2);
      wait_push(2, "t6_first");
      hold[2] = 1'b1;
      send(3, 32'h90, 1);
      repeat (8) begin
         @(negedge w_clk);
         chk("t6_no_early_err", 64'(bus.ERR_TIMEOUT), 64'd0);
      end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
      @(negedge w_clk);
      chk("t6_err_pulse", 64'(bus.ERR_TIMEOUT), 64'd1);
      chk("t6_err_busy",  64'(bus.BUSY),        64'd0);
      @(negedge w_clk);
      chk("t6_err_clear", 64'(bus.ERR_TIMEOUT), 64'd0);
      chk("t6_next_gnt",  64'(bus.GRANT_ID),    64'd3);
      chk("t6_next_busy", 64'(bus.BUSY),        64'd1);
      dq[2].delete();
      lq[2].delete();
      sb[2].delete();
      hold[2] = 1'b0;
      wait_idle("t6_done");
      chk_log("t6", '{2, 3});
`else
      repeat (4) @(negedge w_clk);
      chk("t6_held_err",   64'(bus.ERR_TIMEOUT), 64'd0);
      chk("t6_held_busy",  64'(bus.BUSY),        64'd1);
      chk("t6_held_grant", 64'(bus.GRANT_ID),    64'd2);
      chk("t6_held_wnen",  64'(bus.W_nEN),       64'd1);
      hold[2] = 1'b0;
      wait_idle("t6_done");
      chk_log("t6", '{2, 2, 3});
`endif

      for (int i = 0; i < RC; i++) chk($sformatf("sb_drained%0d", i), 64'(sb[i].size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
